ic_bus_arbiter: RTL and testbench
=================================

# ic_bus_arbiter

Round-robin arbiter that shares the single interconnect bus command/data channel (wr, rd, address, length, wdata, rdata, ready, rddatavalid) between NUM_REQ master FSMs. It sits between the requesting masters and the slave port in the interconnect top level. It latches one requester's command, sequences the command and data beats of that burst on the bus, then releases the bus and rotates priority.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 4: address width
- DATA_W, 32: data width
- LEN_W, 4: burst length width

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req_wr  in  NUM_REQ  per-requester write request
- req_rd  in  NUM_REQ  per-requester read request
- req_address  in  NUM_REQ*ADDR_W  packed addresses; requester i in slice i
- req_length  in  NUM_REQ*LEN_W  packed burst lengths
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_grant  out  NUM_REQ  one-hot grant; high for the whole burst
- req_ready  out  NUM_REQ  command-accept / write-beat-accept strobe to the granted requester
- req_rddatavalid  out  NUM_REQ  read beat valid, granted requester only
- req_rdata  out  DATA_W  shared read data (bus_rdata pass-through)
- bus_wr, bus_rd  out  1  command to slave
- bus_address  out  ADDR_W  latched address
- bus_length  out  LEN_W  latched length
- bus_wdata  out  DATA_W  granted requester's wdata
- bus_ready  in  1  slave accepts command / write beat
- bus_rddatavalid  in  1  slave read beat valid
- bus_rdata  in  DATA_W  slave read data

## Operation
- States: IDLE, CMD, WDATA, RDATA.
- IDLE:
  - A requester is requesting when wr|rd is high. If any is requesting, pick the winner by round-robin starting at pointer `ptr`.
  - Register the grant and the winner's address and length, and set bus_wr/bus_rd. Go to CMD.
- Requester asserting both wr and rd: treated as write; rd is ignored.
- Beat count = length; length 0 is treated as 1 beat. The beat counter is LEN_W bits and counts down to 1.
- CMD:
  - Hold bus_wr/bus_rd/bus_address/bus_length until bus_ready=1.
  - That cycle pulses req_ready of the granted requester and clears bus_wr/bus_rd.
  - Next state is WDATA for a write, RDATA for a read.
- WDATA:
  - bus_wdata is combinationally muxed from the granted requester.
  - Each cycle with bus_ready=1 is one beat: pulse the granted req_ready and decrement the counter.
  - On the last beat, go to IDLE.
- RDATA:
  - Each bus_rddatavalid=1 cycle routes to the granted req_rddatavalid and decrements the counter.
  - The last beat goes to IDLE.
  - bus_rddatavalid outside RDATA is ignored.
- On return to IDLE: ptr ← (granted index + 1) mod NUM_REQ, and req_grant clears.
- Requester inputs changing mid-burst do not affect the latched address/length. Only wdata is sampled live.
- Non-granted requesters see req_ready=0 and req_rddatavalid=0 at all times.

## Timing
- Reset values: state IDLE, ptr 0; req_grant, req_ready, req_rddatavalid all 0; bus_wr, bus_rd 0; bus_address, bus_length 0.
- Reset asserted mid-burst aborts immediately and the bus command drops asynchronously. The slave is expected to be reset together with the arbiter.
- Request sampled in IDLE at edge t: req_grant and bus_wr/bus_rd are high from t+1. Minimum grant latency is 1 cycle.
- req_ready and req_rddatavalid are combinational from bus_ready and bus_rddatavalid, gated by state and grant. There is zero added latency on beats.
- req_rdata always equals bus_rdata.
- There is at least 1 IDLE cycle between bursts. Minimum burst occupancy is 3 cycles: IDLE, CMD, 1 data beat.
- bus_ready in CMD and bus_ready in the following WDATA cycle are separate beats: command accept is never counted as data.

## Configuration
- IC_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins; ptr is removed and stays 0.
  - Undefined (default): round-robin as described.
  - All other behaviour is identical in both builds.

## Structure
- Package ic_bus_pkg holds:
  - state enum (IDLE, CMD, WDATA, RDATA)
  - default widths ADDR_W=4, DATA_W=32, LEN_W=4, shared with the master/slave FSMs
  - the length-0 → 1 normalisation function
- One sub-module, ic_rr_picker: combinational rotate/priority pick of a one-hot winner from a request vector and ptr.
  - Under IC_ARB_FIXED_PRIO_EN it reduces to a plain priority encoder.

## Test plan
- Single read:
  - Stimulus: req1 rd, address 4, length 1; bus_ready pulse 2 cycles after grant; one bus_rddatavalid with rdata 0xA.
  - Response: req_grant=0010 for the burst; req_ready[1] pulses once; req_rddatavalid[1]=1 with rdata 0xA; back to IDLE.
- Write burst:
  - Stimulus: req0 wr, length 3; bus_ready held high.
  - Response: CMD accept, then 3 WDATA beats; bus_wdata follows req_wdata[0]; grant drops after beat 3.
- Round-robin:
  - Stimulus: all 4 requesters hold rd, length 1.
  - Response: grant order 0,1,2,3,0. With IC_ARB_FIXED_PRIO_EN the order is 0,0,0.
- Length 0 and stray beats:
  - Stimulus: length 0 read; a bus_rddatavalid pulse while in IDLE.
  - Response: exactly one beat consumed; the IDLE pulse reaches no requester.
- Reset mid-burst:
  - Stimulus: reset low during WDATA of a length-4 write.
  - Response: all outputs 0 asynchronously; after release, the next request to req2 is granted with ptr at 0.
- Simultaneous wr and rd:
  - Stimulus: req3 asserts wr and rd together.
  - Response: bus_wr=1, bus_rd=0; the burst completes through WDATA.

Source files
------------

// File: rtl/ic_bus_pkg.sv
// Shared types and default widths for the interconnect bus arbiter and its master/slave FSMs.
package ic_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    localparam int IC_ADDR_W = 4;
    localparam int IC_DATA_W = 32;
    localparam int IC_LEN_W  = 4;

    // A zero-length burst still moves one beat.
    function automatic logic [31:0] norm_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/ic_rr_picker.sv
// One-hot winner picker: round-robin from ptr, or plain lowest-index priority
// when IC_ARB_FIXED_PRIO_EN is defined.
module ic_rr_picker
    import ic_bus_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

`ifdef IC_ARB_FIXED_PRIO_EN
    logic ptr_unused;

    assign ptr_unused = ^ptr;
    assign grant      = req & (~req + N'(1));
`else
    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot_req = N'({req, req} >> ptr);
    assign rot_gnt = rot_req & (~rot_req + N'(1));
    assign grant   = N'({rot_gnt, rot_gnt} >> (N - int'(ptr)));
`endif

endmodule

// File: rtl/ic_bus_arbiter.sv
// Round-robin arbiter sharing one bus command/data channel between NUM_REQ masters.
// Define IC_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module ic_bus_arbiter
    import ic_bus_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = IC_ADDR_W,
    parameter int DATA_W  = IC_DATA_W,
    parameter int LEN_W   = IC_LEN_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_wr,
    input  logic [NUM_REQ-1:0]         req_rd,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ*LEN_W-1:0]   req_length,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_rddatavalid,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       bus_wr,
    output logic                       bus_rd,
    output logic [ADDR_W-1:0]          bus_address,
    output logic [LEN_W-1:0]           bus_length,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic                       bus_ready,
    input  logic                       bus_rddatavalid,
    input  logic [DATA_W-1:0]          bus_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [PW-1:0]        ptr_q;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic                 is_wr_q, is_wr_d;
    logic                 burst_done;

    logic [NUM_REQ-1:0]   requesting;
    logic [NUM_REQ-1:0]   pick;
    logic [PW-1:0]        pick_idx;
    logic [ADDR_W-1:0]    pick_addr;
    logic [LEN_W-1:0]     pick_len;

    assign requesting = req_wr | req_rd;

    ic_rr_picker #(.N(NUM_REQ)) u_picker (
        .req   (requesting),
        .ptr   (ptr_q),
        .grant (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign pick_addr = req_address[pick_idx*ADDR_W +: ADDR_W];
    assign pick_len  = req_length[pick_idx*LEN_W +: LEN_W];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        is_wr_d    = is_wr_q;
        burst_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|requesting) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    addr_d  = pick_addr;
                    len_d   = pick_len;
                    cnt_d   = LEN_W'(norm_len(32'(pick_len)));
                    // wr wins when a requester raises both.
                    is_wr_d = req_wr[pick_idx];
                    wr_d    = req_wr[pick_idx];
                    rd_d    = ~req_wr[pick_idx];
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus_ready) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = is_wr_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (bus_ready) begin
                    if (cnt_q == LEN_W'(1)) burst_done = 1'b1;
                    else                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            RDATA: begin
                if (bus_rddatavalid) begin
                    if (cnt_q == LEN_W'(1)) burst_done = 1'b1;
                    else                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (burst_done) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            is_wr_q <= is_wr_d;
        end
    end

`ifdef IC_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [PW-1:0] ptr_d;

    assign ptr_d = !burst_done                       ? ptr_q :
                   (gidx_q == PW'(NUM_REQ - 1))      ? '0    :
                                                       gidx_q + PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    // Beat strobes are combinational so data beats see no added latency.
    assign req_ready       = ((state_q == CMD) || (state_q == WDATA)) ?
                             (grant_q & {NUM_REQ{bus_ready}}) : '0;
    assign req_rddatavalid = (state_q == RDATA) ? (grant_q & {NUM_REQ{bus_rddatavalid}}) : '0;
    assign req_rdata       = bus_rdata;
    assign req_grant       = grant_q;
    assign bus_wr          = wr_q;
    assign bus_rd          = rd_q;
    assign bus_address     = addr_q;
    assign bus_length      = len_q;
    assign bus_wdata       = req_wdata[gidx_q*DATA_W +: DATA_W];

endmodule

// File: tb/tb_ic_bus_arbiter.sv
// Self-checking bench for ic_bus_arbiter: scenario tasks with a scoreboard queue of expectations.
module tb_ic_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_wr, req_rd;
    logic [N*AW-1:0]   req_address;
    logic [N*LW-1:0]   req_length;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_grant, req_ready, req_rddatavalid;
    logic [DW-1:0]     req_rdata, bus_wdata, bus_rdata;
    logic              bus_wr, bus_rd, bus_ready, bus_rddatavalid;
    logic [AW-1:0]     bus_address;
    logic [LW-1:0]     bus_length;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    always #5 clock = ~clock;

    ic_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_wr          (req_wr),
        .req_rd          (req_rd),
        .req_address     (req_address),
        .req_length      (req_length),
        .req_wdata       (req_wdata),
        .req_grant       (req_grant),
        .req_ready       (req_ready),
        .req_rddatavalid (req_rddatavalid),
        .req_rdata       (req_rdata),
        .bus_wr          (bus_wr),
        .bus_rd          (bus_rd),
        .bus_address     (bus_address),
        .bus_length      (bus_length),
        .bus_wdata       (bus_wdata),
        .bus_ready       (bus_ready),
        .bus_rddatavalid (bus_rddatavalid),
        .bus_rdata       (bus_rdata)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_wr = '0; req_rd = '0; req_address = '0; req_length = '0; req_wdata = '0;
        bus_ready = 1'b1; bus_rddatavalid = 1'b1; bus_rdata = 32'h1234_5678;
        #3;
        n_tests++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", req_grant); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_tests++; if (req_rddatavalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rddv: got %b want 0000", req_rddatavalid); end
        n_tests++; if ({bus_wr, bus_rd} !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: got %b want 00", {bus_wr, bus_rd}); end
        n_tests++; if ({bus_address, bus_length} !== 8'h00) begin n_fail++; $display("FAIL reset_addr_len: got %h want 00", {bus_address, bus_length}); end
        n_tests++; if (req_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rdata_passthru: got %h want 12345678", req_rdata); end
        bus_ready = 1'b0; bus_rddatavalid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_round_robin();
        int           got = 0;
        logic [N-1:0] prev = '0;
        for (int k = 0; k < 5; k++) begin
`ifdef IC_ARB_FIXED_PRIO_EN
            exp_q.push_back(32'h1);
`else
            exp_q.push_back(32'(1) << (k % N));
`endif
        end
        for (int i = 0; i < N; i++) req_length[i*LW +: LW] = 4'd1;
        req_rd = '1; bus_ready = 1'b1; bus_rddatavalid = 1'b1; bus_rdata = 32'h55;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            sample();
            if (req_grant !== 4'b0000 && prev === 4'b0000) begin
                exp = exp_q.pop_front();
                n_tests++; if (32'(req_grant) !== exp) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", got, req_grant, exp[3:0]); end
                $display("[TB] rr burst %0d grant=%b", got, req_grant);
                got++;
                if (got == 5) req_rd = '0;
            end
            prev = req_grant;
        end
        n_tests++; if (got != 5) begin n_fail++; $display("FAIL rr_timeout: got %0d grants want 5", got); req_rd = '0; end
        for (int cyc = 0; cyc < 10 && req_grant !== 4'b0000; cyc++) sample();
        n_tests++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL rr_release: got %b want 0000", req_grant); end
        step();
        bus_ready = 1'b0; bus_rddatavalid = 1'b0;
        exp_q.delete();
        step();
    endtask

    task automatic test_single_read();
        req_rd[1] = 1'b1; req_address[1*AW +: AW] = 4'd4; req_length[1*LW +: LW] = 4'd1;
        step();
        req_rd = '0;
        sample();
        n_tests++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL rd_grant: got %b want 0010", req_grant); end
        n_tests++; if ({bus_wr, bus_rd} !== 2'b01) begin n_fail++; $display("FAIL rd_cmd: got %b want 01", {bus_wr, bus_rd}); end
        n_tests++; if (bus_address !== 4'd4 || bus_length !== 4'd1) begin n_fail++; $display("FAIL rd_addr_len: got %h/%h want 4/1", bus_address, bus_length); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rd_ready_early: got %b want 0000", req_ready); end
        step();
        bus_ready = 1'b1;
        sample();
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rd_cmd_accept: got %b want 0010", req_ready); end
        step();
        bus_ready = 1'b0; bus_rddatavalid = 1'b1; bus_rdata = 32'hA;
        exp_q.push_back(32'hA);
        sample();
        n_tests++; if (bus_rd !== 1'b0) begin n_fail++; $display("FAIL rd_cmd_drop: got %b want 0", bus_rd); end
        n_tests++; if (req_rddatavalid !== 4'b0010) begin n_fail++; $display("FAIL rd_rddv: got %b want 0010", req_rddatavalid); end
        exp = exp_q.pop_front();
        n_tests++; if (req_rdata !== exp) begin n_fail++; $display("FAIL rd_data: got %h want %h", req_rdata, exp); end
        step();
        bus_rddatavalid = 1'b0;
        sample();
        n_tests++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL rd_release: got %b want 0000", req_grant); end
        $display("[TB] single read req1 addr=4 rdata=%h", req_rdata);
        step();
    endtask

    task automatic test_write_burst();
        req_wr[0] = 1'b1; req_address[0*AW +: AW] = 4'd7; req_length[0*LW +: LW] = 4'd3;
        req_wdata[0*DW +: DW] = 32'hC0DE_00FF; bus_ready = 1'b1;
        step();
        req_wr = '0;
        sample();
        n_tests++; if (req_grant !== 4'b0001 || bus_wr !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got %b/%b want 0001/1", req_grant, bus_wr); end
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wr_cmd_accept: got %b want 0001", req_ready); end
        step();
        for (int b = 0; b < 3; b++) begin
            req_wdata[0*DW +: DW] = 32'hC0DE_0000 + 32'(b);
            exp_q.push_back(32'hC0DE_0000 + 32'(b));
            sample();
            exp = exp_q.pop_front();
            n_tests++; if (bus_wdata !== exp) begin n_fail++; $display("FAIL wr_wdata_%0d: got %h want %h", b, bus_wdata, exp); end
            n_tests++; if (req_ready !== 4'b0001 || req_grant !== 4'b0001 || bus_wr !== 1'b0) begin
                n_fail++; $display("FAIL wr_beat_%0d: got ready=%b grant=%b wr=%b want 0001/0001/0", b, req_ready, req_grant, bus_wr);
            end
            step();
        end
        bus_ready = 1'b0;
        sample();
        n_tests++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL wr_release: got %b want 0000", req_grant); end
        $display("[TB] write burst req0 len=3 done");
        step();
    endtask

    task automatic test_len0_stray();
        bus_rddatavalid = 1'b1;
        sample();
        n_tests++; if (req_rddatavalid !== 4'b0000) begin n_fail++; $display("FAIL stray_idle: got %b want 0000", req_rddatavalid); end
        step();
        bus_rddatavalid = 1'b0;
        req_rd[2] = 1'b1; req_address[2*AW +: AW] = 4'd2; req_length[2*LW +: LW] = 4'd0; bus_ready = 1'b1;
        step();
        req_rd = '0;
        sample();
        n_tests++; if (req_grant !== 4'b0100 || bus_length !== 4'd0) begin n_fail++; $display("FAIL len0_cmd: got %b/%h want 0100/0", req_grant, bus_length); end
        step();
        bus_ready = 1'b0; bus_rddatavalid = 1'b1;
        sample();
        n_tests++; if (req_rddatavalid !== 4'b0100) begin n_fail++; $display("FAIL len0_beat: got %b want 0100", req_rddatavalid); end
        step();
        sample();
        n_tests++; if (req_grant !== 4'b0000 || req_rddatavalid !== 4'b0000) begin
            n_fail++; $display("FAIL len0_one_beat: got grant=%b rddv=%b want 0000/0000", req_grant, req_rddatavalid);
        end
        bus_rddatavalid = 1'b0;
        $display("[TB] length-0 read req2 done");
        step();
    endtask

    task automatic test_reset_mid();
        req_wr[0] = 1'b1; req_address[0*AW +: AW] = 4'd9; req_length[0*LW +: LW] = 4'd4; bus_ready = 1'b1;
        step();
        req_wr = '0;
        step();
        sample();
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_pre_beat: got %b want 0001", req_ready); end
        #1 reset = 1'b0;
        #1;
        n_tests++; if (req_grant !== 4'b0000 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_async: got grant=%b ready=%b want 0000/0000", req_grant, req_ready);
        end
        n_tests++; if ({bus_wr, bus_rd, bus_address, bus_length} !== 10'd0) begin
            n_fail++; $display("FAIL rst_async_bus: got %b want 0", {bus_wr, bus_rd, bus_address, bus_length});
        end
        bus_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        req_rd = 4'b1100; req_length[2*LW +: LW] = 4'd1; req_length[3*LW +: LW] = 4'd1;
        step();
        req_rd = '0;
        sample();
        n_tests++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL rst_ptr: got %b want 0100", req_grant); end
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0; bus_rddatavalid = 1'b1;
        step();
        bus_rddatavalid = 1'b0;
        sample();
        n_tests++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL rst_post_release: got %b want 0000", req_grant); end
        $display("[TB] reset mid-burst then req2 read done");
        step();
    endtask

    task automatic test_wr_rd();
        req_wr[3] = 1'b1; req_rd[3] = 1'b1; req_length[3*LW +: LW] = 4'd1;
        req_wdata[3*DW +: DW] = 32'hBEEF_0003;
        step();
        req_wr = '0; req_rd = '0; bus_ready = 1'b1;
        sample();
        n_tests++; if ({bus_wr, bus_rd} !== 2'b10 || req_grant !== 4'b1000) begin
            n_fail++; $display("FAIL wrrd_cmd: got wr/rd=%b grant=%b want 10/1000", {bus_wr, bus_rd}, req_grant);
        end
        step();
        exp_q.push_back(32'hBEEF_0003);
        sample();
        exp = exp_q.pop_front();
        n_tests++; if (req_ready !== 4'b1000 || bus_wdata !== exp) begin
            n_fail++; $display("FAIL wrrd_wbeat: got ready=%b wdata=%h want 1000/%h", req_ready, bus_wdata, exp);
        end
        step();
        bus_ready = 1'b0;
        sample();
        n_tests++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL wrrd_release: got %b want 0000", req_grant); end
        $display("[TB] wr+rd req3 treated as write");
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_burst();
        test_len0_stray();
        test_reset_mid();
        test_wr_rd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
